// File: rtl/led_share_sched.sv
// Round-robin LED scheduler: grants one of four pattern sources for a dwell period
// and mirrors its pattern onto the LEDs; a debounced push-button freezes rotation.
module led_share_sched #(
  parameter int unsigned DWELL_CYCLES    = 12000000,
  parameter int unsigned DEBOUNCE_CYCLES = 120000
) (
  input  logic        in_clock,
  input  logic        in_reset_n,
  input  logic [3:0]  in_req,
  input  logic [19:0] in_pattern,
  input  logic        in_hold,
  output logic [4:0]  out_led,
  output logic [3:0]  out_grant,
  output logic        out_held
);

  typedef enum logic [1:0] {IDLE, SHOW, HOLD} state_t;

  state_t      r_state;
  logic [3:0]  r_grant;
  logic [1:0]  r_gidx;
  logic [1:0]  r_ptr;
  logic [31:0] r_cnt;
  logic [4:0]  r_led;
  logic        r_held;
  logic        r_sync1;
  logic        r_sync2;
  logic        r_db_lvl;
  logic        r_db_lvl_d;
  logic [31:0] r_db_cnt;

  logic [3:0]  w_mask;
  logic        w_any;
  logic [1:0]  w_pick;
  logic [1:0]  w_cand;
  logic [4:0]  w_pick_pat;
  logic [4:0]  w_cur_pat;
  logic        w_cur_req;
  logic        w_press;
  logic        w_expire;

  // Excluding the current grant serves both the dwell switch and the request-drop re-pick.
  assign w_mask    = in_req & ~r_grant;
  assign w_any     = |w_mask;
  assign w_cur_req = |(in_req & r_grant);
  assign w_expire  = (r_cnt == DWELL_CYCLES - 1);
  assign w_press   = r_db_lvl & ~r_db_lvl_d;

  always_comb begin
    w_pick = r_ptr;
    w_cand = r_ptr;
    for (int k = 3; k >= 0; k--) begin
      w_cand = r_ptr + 2'(k);
      if (w_mask[w_cand]) w_pick = w_cand;
    end
  end

  assign w_pick_pat = in_pattern[w_pick * 5 +: 5];
  assign w_cur_pat  = in_pattern[r_gidx * 5 +: 5];

  always_ff @(posedge in_clock or negedge in_reset_n) begin
    if (!in_reset_n) begin
      r_sync1    <= 1'b0;
      r_sync2    <= 1'b0;
      r_db_lvl   <= 1'b0;
      r_db_lvl_d <= 1'b0;
      r_db_cnt   <= '0;
    end else begin
      r_sync1    <= in_hold;
      r_sync2    <= r_sync1;
      r_db_lvl_d <= r_db_lvl;
      if (r_sync2 == r_db_lvl) begin
        r_db_cnt <= '0;
      end else if (r_db_cnt == DEBOUNCE_CYCLES - 1) begin
        r_db_cnt <= '0;
        r_db_lvl <= r_sync2;
      end else begin
        r_db_cnt <= r_db_cnt + 32'd1;
      end
    end
  end

  always_ff @(posedge in_clock or negedge in_reset_n) begin
    if (!in_reset_n) begin
      r_state <= IDLE;
      r_grant <= '0;
      r_gidx  <= '0;
      r_ptr   <= '0;
      r_cnt   <= '0;
      r_led   <= '0;
      r_held  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_led <= '0;
          if (w_any) begin
            r_state <= SHOW;
            r_grant <= 4'b0001 << w_pick;
            r_gidx  <= w_pick;
            r_ptr   <= w_pick + 2'd1;
            r_cnt   <= '0;
            r_led   <= w_pick_pat;
          end
        end
        SHOW, HOLD: begin
          if (!w_cur_req) begin
            r_held <= 1'b0;
            r_cnt  <= '0;
            if (w_any) begin
              r_state <= SHOW;
              r_grant <= 4'b0001 << w_pick;
              r_gidx  <= w_pick;
              r_ptr   <= w_pick + 2'd1;
              r_led   <= w_pick_pat;
            end else begin
              r_state <= IDLE;
              r_grant <= '0;
              r_led   <= '0;
            end
          end else if (w_press) begin
            r_led <= w_cur_pat;
            if (r_state == SHOW) begin
              r_state <= HOLD;
              r_held  <= 1'b1;
            end else begin
              r_state <= SHOW;
              r_held  <= 1'b0;
              r_cnt   <= '0;
            end
          end else if (r_state == HOLD) begin
            r_led <= w_cur_pat;
          end else if (w_expire) begin
            r_cnt <= '0;
            if (w_any) begin
              r_grant <= 4'b0001 << w_pick;
              r_gidx  <= w_pick;
              r_ptr   <= w_pick + 2'd1;
              r_led   <= w_pick_pat;
            end else begin
              r_led <= w_cur_pat;
            end
          end else begin
            r_cnt <= r_cnt + 32'd1;
            r_led <= w_cur_pat;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign out_led   = r_led;
  assign out_grant = r_grant;
  assign out_held  = r_held;

endmodule

// File: tb/tb_led_share_sched.sv
// Bench for led_share_sched with DWELL_CYCLES=8, DEBOUNCE_CYCLES=4.
module tb_led_share_sched;

  logic        in_clock   = 1'b0;
  logic        in_reset_n = 1'b0;
  logic [3:0]  in_req     = 4'b0000;
  logic        in_hold    = 1'b0;
  logic [19:0] in_pattern;
  logic [4:0]  out_led;
  logic [3:0]  out_grant;
  logic        out_held;
  logic [4:0]  pat [4];

  int n_chk  = 0;
  int n_pass = 0;

  typedef struct {
    logic [3:0] g;
    logic [4:0] led;
    logic       held;
    string      nm;
  } exp_t;

  typedef struct {
    logic [3:0] req;
    logic       hold;
    logic [3:0] g;
    logic       held;
  } vec_t;

  exp_t sb[$];
  vec_t vtab[$];

  assign in_pattern = {pat[3], pat[2], pat[1], pat[0]};

  led_share_sched #(.DWELL_CYCLES(8), .DEBOUNCE_CYCLES(4)) dut (
    .in_clock  (in_clock),
    .in_reset_n(in_reset_n),
    .in_req    (in_req),
    .in_pattern(in_pattern),
    .in_hold   (in_hold),
    .out_led   (out_led),
    .out_grant (out_grant),
    .out_held  (out_held)
  );

  always #5 in_clock = ~in_clock;

  function automatic logic [4:0] led_of(input logic [3:0] g);
    case (g)
      4'b0001: return pat[0];
      4'b0010: return pat[1];
      4'b0100: return pat[2];
      4'b1000: return pat[3];
      default: return 5'd0;
    endcase
  endfunction

  task automatic check(input string nm, input logic [3:0] eg, input logic [4:0] el, input logic eh);
    n_chk++;
    if (out_grant === eg && out_led === el && out_held === eh) begin
      n_pass++;
    end else begin
      $display("FAIL %s @%0t: grant=%b led=%h held=%b, expected grant=%b led=%h held=%b",
               nm, $time, out_grant, out_led, out_held, eg, el, eh);
    end
  endtask

  // Drive one cycle of stimulus, queue its expectation, compare after the edge.
  task automatic cyc(input logic [3:0] req, input logic hold, input logic [3:0] eg,
                     input logic eh, input string nm);
    exp_t e;
    in_req  = req;
    in_hold = hold;
    e.g    = eg;
    e.led  = led_of(eg);
    e.held = eh;
    e.nm   = nm;
    sb.push_back(e);
    @(posedge in_clock);
    #1;
    if (sb.size() == 0) begin
      n_chk++;
      $display("FAIL %s: scoreboard empty, expected one entry", nm);
    end else begin
      e = sb.pop_front();
      check(e.nm, e.g, e.led, e.held);
    end
  endtask

  task automatic run(input int n, input logic [3:0] req, input logic hold, input logic [3:0] eg,
                     input logic eh, input string nm);
    repeat (n) cyc(req, hold, eg, eh, nm);
  endtask

  task automatic add(input int n, input logic [3:0] req, input logic [3:0] g);
    vec_t v;
    v.req  = req;
    v.hold = 1'b0;
    v.g    = g;
    v.held = 1'b0;
    repeat (n) vtab.push_back(v);
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached, expected earlier finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] rot [4];
    pat[0] = 5'h11;
    pat[1] = 5'h0A;
    pat[2] = 5'h15;
    pat[3] = 5'h1E;

    // Request-drop scenarios: drop at counter 3 and at counter 7, both land on source 3.
    add(1, 4'b1011, 4'b0010);
    add(3, 4'b1011, 4'b0010);
    add(1, 4'b1001, 4'b1000);
    add(7, 4'b1001, 4'b1000);
    add(1, 4'b1011, 4'b0001);
    add(7, 4'b1011, 4'b0001);
    add(1, 4'b1011, 4'b0010);
    add(7, 4'b1011, 4'b0010);
    add(1, 4'b1001, 4'b1000);
    add(7, 4'b1001, 4'b1000);
    add(1, 4'b1001, 4'b0001);

    repeat (3) @(posedge in_clock);
    #1;
    check("reset", 4'b0000, 5'd0, 1'b0);
    in_reset_n = 1'b1;
    run(20, 4'b0000, 1'b0, 4'b0000, 1'b0, "idle");

    rot[0] = 4'b0001;
    rot[1] = 4'b0010;
    rot[2] = 4'b1000;
    rot[3] = 4'b0001;
    for (int s = 0; s < 4; s++) run(8, 4'b1011, 1'b0, rot[s], 1'b0, "rotation");

    for (int i = 0; i < vtab.size(); i++)
      cyc(vtab[i].req, vtab[i].hold, vtab[i].g, vtab[i].held, "drop_tbl");

    // Short glitch on the button must not freeze rotation.
    run(3, 4'b1011, 1'b1, 4'b0001, 1'b0, "glitch");
    run(4, 4'b1011, 1'b0, 4'b0001, 1'b0, "glitch");
    cyc(4'b1011, 1'b0, 4'b0010, 1'b0, "glitch_sw");

    // Press lands on the dwell-expiry edge: hold wins, no switch.
    cyc(4'b1011, 1'b0, 4'b0010, 1'b0, "pre_hold");
    run(6, 4'b1011, 1'b1, 4'b0010, 1'b0, "hold_wait");
    run(4, 4'b1011, 1'b1, 4'b0010, 1'b1, "hold_on");
    run(18, 4'b1011, 1'b0, 4'b0010, 1'b1, "frozen");
    pat[1] = 5'h03;
    run(18, 4'b1011, 1'b0, 4'b0010, 1'b1, "frozen_pat");

    run(6, 4'b1011, 1'b1, 4'b0010, 1'b1, "press2_wait");
    run(4, 4'b1011, 1'b1, 4'b0010, 1'b0, "resume");
    run(4, 4'b1011, 1'b0, 4'b0010, 1'b0, "resume");
    cyc(4'b1011, 1'b0, 4'b1000, 1'b0, "resume_sw");

    run(7, 4'b1011, 1'b0, 4'b1000, 1'b0, "rot");
    cyc(4'b1011, 1'b0, 4'b0001, 1'b0, "rot_sw");

    // Granted request drops while held.
    run(6, 4'b1011, 1'b1, 4'b0001, 1'b0, "p3_wait");
    run(4, 4'b1011, 1'b1, 4'b0001, 1'b1, "p3_on");
    run(2, 4'b1011, 1'b0, 4'b0001, 1'b1, "p3_held");
    cyc(4'b1010, 1'b0, 4'b0010, 1'b0, "hold_drop");

    // Enter HOLD with counter at 5, then reset asynchronously.
    run(7, 4'b1010, 1'b0, 4'b0010, 1'b0, "rot2");
    cyc(4'b1010, 1'b1, 4'b1000, 1'b0, "g4");
    run(5, 4'b1010, 1'b1, 4'b1000, 1'b0, "p4_wait");
    cyc(4'b1010, 1'b1, 4'b1000, 1'b1, "p4_on");
    #2;
    in_reset_n = 1'b0;
    #1;
    check("async_rst", 4'b0000, 5'd0, 1'b0);
    in_hold = 1'b0;
    in_req  = 4'b0110;
    @(posedge in_clock);
    #1;
    check("in_rst", 4'b0000, 5'd0, 1'b0);
    in_reset_n = 1'b1;
    cyc(4'b0110, 1'b0, 4'b0010, 1'b0, "post_rst");
    run(7, 4'b0110, 1'b0, 4'b0010, 1'b0, "post_rst");
    cyc(4'b0110, 1'b0, 4'b0100, 1'b0, "post_rst_sw");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/led_share_sched.md
# led_share_sched

Round-robin display scheduler that time-shares the board's five LEDs among up to four pattern sources, e.g. the free-running heartbeat counter, a submodule's `out_led` byte and PMOD-driven test patterns. Each source requests the display with a level `req` and presents a 5-bit pattern. The block grants one source at a time for a fixed dwell period and mirrors that source's pattern onto the LEDs. A debounced PMOD push-button freezes rotation on the current source. It sits between the pattern generators and the LED pins in the top-level wrapper.

## Interface
- `DWELL_CYCLES`, 12000000: cycles per grant when other sources are waiting (1 s at 12 MHz); legal range ≥2, < 2^32.
- `DEBOUNCE_CYCLES`, 120000: consecutive stable cycles required before the hold button's debounced level changes; legal range ≥1.

- `in_clock`  in  1  system clock.
- `in_reset_n`  in  1  reset, asynchronous, active-low.
- `in_req`  in  4  per-source display request, level-sensitive, synchronous to `in_clock`.
- `in_pattern`  in  20  packed patterns; source i occupies bits [5i+4:5i].
- `in_hold`  in  1  raw push-button, asynchronous, active-high.
- `out_led`  out  5  registered pattern of the granted source.
- `out_grant`  out  4  one-hot grant; zero when idle.
- `out_held`  out  1  high while rotation is frozen.

## Operation
- Reset values: state IDLE, `out_led`=0, `out_grant`=0, `out_held`=0, dwell counter=0, round-robin pointer=0, synchronizer flops=0, debounced level=0, debounce counter=0.
- Round-robin pick: the first requesting source scanning ptr, ptr+1, … mod 4. On every grant, ptr becomes granted+1 mod 4.
- IDLE
  - If any `in_req` bit is set: pick, then go to SHOW with counter=0.
  - A hold press here is ignored.
- SHOW
  - Counter increments each cycle.
  - If the granted `req` drops: re-pick excluding the current source. Go to SHOW (counter=0), or to IDLE if no source is requesting.
  - If counter==DWELL_CYCLES-1 and another source is requesting: switch to the next requester and set counter=0.
  - If counter==DWELL_CYCLES-1 and no other source is requesting: keep the grant and set counter=0.
  - Debounced hold press: go to HOLD and set `out_held`=1. The counter freezes.
- HOLD
  - Grant and counter are frozen.
  - Another debounced press: return to SHOW with counter=0 and `out_held`=0.
  - If the granted `req` drops: clear `out_held` and re-pick as in SHOW.
- Simultaneous events:
  - Request drop beats dwell expiry and beats a hold press.
  - A hold press beats dwell expiry, so no switch occurs.
- `out_led` loads `in_pattern` of the newly granted source on the grant edge. It then tracks that source's pattern with 1-cycle latency. It is 0 in IDLE.
- Hold input path
  - Two-flop synchronizer.
  - Then a counter of consecutive cycles in which the synchronized value differs from the debounced level. The counter clears when the values match. The debounced level flips when the count reaches DEBOUNCE_CYCLES.
  - Press = rising edge of the debounced level. Release events are ignored.
- Reset asserted mid-operation: all state returns immediately and asynchronously to the reset values, regardless of state.

## Timing
- Request to grant: `in_req` high at edge N in IDLE → `out_grant` and `out_led` valid after edge N.
- Dwell: with competing requesters, each grant lasts exactly DWELL_CYCLES cycles.
- Request drop: granted `req` low at edge N → new grant, or zero, after edge N. There are no dead cycles.
- Hold: `in_hold` high and stable from edge N → `out_held` high after edge N+DEBOUNCE_CYCLES+2. Input glitches shorter than DEBOUNCE_CYCLES produce no press.
- Pattern: change of the granted pattern before edge N → `out_led` updated after edge N.

## Test plan
DWELL_CYCLES=8, DEBOUNCE_CYCLES=4.
- Reset release with `in_req`=0 → `out_led`=0, `out_grant`=0 and `out_held`=0 held for 20 cycles.
- `in_req`=4'b1011 held → grant sequence 0001, 0010, 1000, 0001, each lasting exactly 8 cycles. `out_led` equals the matching 5-bit slice.
- Source 1 granted; its `req` drops at counter=3 → source 3 granted on that edge with counter=0. Drop coinciding with counter=7 gives the same result.
- `in_hold` pulsed for 3 cycles → no HOLD. Pulsed for 10 cycles → `out_held`=1 after DEBOUNCE_CYCLES+2 edges and the grant is frozen for 40 cycles. A second press → rotation resumes with a full 8-cycle dwell.
- In HOLD, the granted `req` drops → `out_held`=0 and the next requester is granted on the same edge.
- `in_reset_n` asserted mid-HOLD with the counter at 5 → all outputs are 0 immediately. After release, the first grant goes to the lowest requesting index (ptr=0).
